switch_allocator: RTL and testbench
===================================

# switch_allocator

Router-level switch allocator that shares the five router output ports among the five input channels. Each input channel raises a one-hot output-port request. Per output port, the allocator picks one winner by round-robin, gated by downstream credit availability. It then holds that input→output binding for the whole packet (wormhole) until the input signals release, and drives the crossbar select for each output. It sits beside the per-channel assembled channels and replaces their individual sa_grant sources.

## Interface
Parameters:
- P_CHANNELS, default `CHANNELS (5): number of input channels and output ports
- P_SEL_WIDTH, default 3: width of one crossbar select index; ≥ clog2(P_CHANNELS)
- P_CREDIT_WIDTH, default `BUFFERSIZE_WIDTH: width of one downstream credit count

Ports:
- CLK  in  1  clock; all state on rising edge
- RST  in  1  reset, asynchronous, active-low
- in_sa_enable  in  P_CHANNELS  input i requests allocation this cycle
- in_sa_request  in  P_CHANNELS*P_CHANNELS  bits [i*P_CHANNELS +: P_CHANNELS] = input i's one-hot output request
- in_release  in  P_CHANNELS  one-cycle pulse from input i when its tail flit leaves
- in_out_credits  in  P_CHANNELS*P_CREDIT_WIDTH  slice o = free credits at downstream of output o
- out_sa_grant  out  P_CHANNELS  high while input i owns an output
- out_xbar_sel  out  P_CHANNELS*P_SEL_WIDTH  slice o = index of the input owning output o
- out_xbar_valid  out  P_CHANNELS  output o is locked to an owner
- out_req_error  out  1  one-cycle pulse: a malformed request was seen the previous cycle

## Operation
- Per output o, state is lock[o], owner[o] (P_SEL_WIDTH bits) and rr_ptr[o] (P_SEL_WIDTH bits).
- A request from input i to output o is valid when all of these hold:
  - in_sa_enable[i] = 1.
  - The request slice is exactly one-hot, with bit o set.
  - Input i holds no current grant.
- A valid enable with a zero or multi-hot slice is ignored, and out_req_error pulses the next cycle.
- Output o is eligible for arbitration in a cycle when lock[o]=0 and credits[o] ≠ 0.
- Arbitration: among valid requesters of output o, the winner is the first index found searching from rr_ptr[o] upward, modulo P_CHANNELS.
- On a win:
  - lock[o] ← 1.
  - owner[o] ← winner.
  - rr_ptr[o] ← (winner+1) mod P_CHANNELS.
- Per-output arbitration is independent. Each input requests only one output, so one input can never win two outputs.
- While locked:
  - out_sa_grant[owner] = 1.
  - out_xbar_sel slice = owner.
  - out_xbar_valid[o] = 1.
  - Requests and credit changes are ignored. Dropping in_sa_enable does not release the lock.
- Release: in_release[i] clears lock[o] for the output whose owner = i. A release from an input holding nothing is ignored.
- out_xbar_sel for an unlocked output is 0.
- Per-output state is two-state: FREE ↔ LOCKED. FREE→LOCKED on a win; LOCKED→FREE on the owner's release.

## Timing
- Reset (RST=0, asynchronous): lock, owner and rr_ptr all cleared; all outputs 0.
- Grant latency: a request sampled at edge N gives out_sa_grant high after edge N (registered, 1 cycle).
- Release sampled at edge N makes the output FREE after edge N. New arbitration for it uses requests sampled at edge N+1, so there is one idle cycle (no bypass).
- Release and a new request for the same output in the same cycle: the request is not granted that cycle. It must be held and wins at the next edge if it is first in RR order.
- out_req_error is registered; it is high for exactly the one cycle after the malformed sample.
- Reset asserted mid-packet drops all locks immediately. Outputs go to 0 asynchronously.

## Structure
- `CHANNELS and `BUFFERSIZE_WIDTH come from the shared parameters.v; no new globals.
- Flattened-bus slice macros go in parameters.v if reused by other blocks.
- One natural sub-module, rr_arbiter: a P_CHANNELS-wide request vector plus pointer, giving a one-hot grant and an encoded index. It is instantiated once per output.
- Lock, owner and pointer registers live in the top level.

## Test plan
- Single request: input 2 requests output 1 (00010), credits 4 → out_sa_grant=00100 next cycle, out_xbar_sel[1]=2, out_xbar_valid=00010. The grant holds until in_release[2]; the output is FREE the cycle after release.
- Contention: inputs 0, 3 and 4 all request output 2 with rr_ptr=0.
  - Grant order across three packets (release after each) is 0, 3, 4.
  - rr_ptr[2] then equals 0 (wraps after 4).
- Credit gating: input 1 requests output 0 with credits[0]=0 → no grant. Raise credits to 1 → grant the next cycle.
- Malformed request: enable with slice 00110 → no grant; out_req_error=1 for one cycle. A zero slice gives the same result.
- Simultaneous release and re-request: input 0 owns output 3 and input 1 requests output 3.
  - Release from 0 in cycle N → output 3 FREE after N.
  - Input 1 is granted after edge N+1, not N.
- Reset mid-packet: two outputs locked, pulse RST low asynchronously (off a clock edge).
  - All outputs drop to 0 immediately.
  - After deassertion, the same requests re-arbitrate from rr_ptr=0.

Source files
------------

// File: rtl/switch_allocator_pkg.sv
// Shared constants and types for the router switch allocator.
// Defaults mirror the router-wide channel count and credit width.
package switch_allocator_pkg;

    localparam int CHANNELS         = 5;
    localparam int BUFFERSIZE_WIDTH = 4;
    localparam int SEL_WIDTH        = 3;

    typedef enum logic {
        ST_FREE   = 1'b0,
        ST_LOCKED = 1'b1
    } port_state_e;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: first set request searching upward from the pointer,
// wrapping modulo P_N. Produces a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int P_N  = 5,
    parameter int P_SW = 3
) (
    input  logic [P_N-1:0]  i_req,
    input  logic [P_SW-1:0] i_ptr,
    output logic [P_N-1:0]  o_gnt,
    output logic [P_SW-1:0] o_idx
);

    logic w_found;
    int   w_pos;

    // Rotating priority search starting at the pointer
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < P_N; k++) begin
            w_pos = int'(i_ptr) + k;
            if (w_pos >= P_N) begin
                w_pos = w_pos - P_N;
            end else begin
                w_pos = w_pos;
            end
            if (!w_found && i_req[w_pos]) begin
                w_found      = 1'b1;
                o_gnt[w_pos] = 1'b1;
                o_idx        = P_SW'(w_pos);
            end else begin
                w_found = w_found;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output round-robin arbitration gated by
// downstream credits, holding each input->output binding until release.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int P_CHANNELS     = CHANNELS,
    parameter int P_SEL_WIDTH    = SEL_WIDTH,
    parameter int P_CREDIT_WIDTH = BUFFERSIZE_WIDTH
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic [P_CHANNELS-1:0]                in_sa_enable,
    input  logic [P_CHANNELS*P_CHANNELS-1:0]     in_sa_request,
    input  logic [P_CHANNELS-1:0]                in_release,
    input  logic [P_CHANNELS*P_CREDIT_WIDTH-1:0] in_out_credits,
    output logic [P_CHANNELS-1:0]                out_sa_grant,
    output logic [P_CHANNELS*P_SEL_WIDTH-1:0]    out_xbar_sel,
    output logic [P_CHANNELS-1:0]                out_xbar_valid,
    output logic                                 out_req_error
);

    port_state_e            r_state     [P_CHANNELS];
    port_state_e            w_state_nxt [P_CHANNELS];
    logic [P_SEL_WIDTH-1:0] r_owner     [P_CHANNELS];
    logic [P_SEL_WIDTH-1:0] w_owner_nxt [P_CHANNELS];
    logic [P_SEL_WIDTH-1:0] r_ptr       [P_CHANNELS];
    logic [P_SEL_WIDTH-1:0] w_ptr_nxt   [P_CHANNELS];
    logic [P_CHANNELS-1:0]  w_req_col   [P_CHANNELS];
    logic [P_CHANNELS-1:0]  w_arb_gnt   [P_CHANNELS];
    logic [P_SEL_WIDTH-1:0] w_arb_idx   [P_CHANNELS];
    logic [P_SEL_WIDTH-1:0] w_sel       [P_CHANNELS];
    logic [P_CHANNELS-1:0]  w_arb_any;
    logic [P_CHANNELS-1:0]  w_eligible;
    logic [P_CHANNELS-1:0]  w_rel;
    logic [P_CHANNELS-1:0]  w_grant;
    logic [P_CHANNELS-1:0]  w_valid;
    logic [P_CHANNELS-1:0]  w_slice;
    logic                   w_req_err;
    logic                   r_req_error;

    function automatic logic f_is_onehot(input logic [P_CHANNELS-1:0] v);
        return (v != '0) && ((v & (v - P_CHANNELS'(1))) == '0);
    endfunction

    // Transpose well-formed requests from idle inputs into per-output requester vectors
    always_comb begin
        w_req_err = 1'b0;
        w_slice   = '0;
        for (int o = 0; o < P_CHANNELS; o++) begin
            w_req_col[o] = '0;
        end
        for (int i = 0; i < P_CHANNELS; i++) begin
            w_slice = in_sa_request[i*P_CHANNELS +: P_CHANNELS];
            if (in_sa_enable[i] && !w_grant[i]) begin
                if (f_is_onehot(w_slice)) begin
                    for (int o = 0; o < P_CHANNELS; o++) begin
                        w_req_col[o][i] = w_slice[o];
                    end
                end else begin
                    w_req_err = 1'b1;
                end
            end else begin
                w_req_err = w_req_err;
            end
        end
    end

    for (genvar o = 0; o < P_CHANNELS; o++) begin : g_arb
        rr_arbiter #(
            .P_N  (P_CHANNELS),
            .P_SW (P_SEL_WIDTH)
        ) u_arb (
            .i_req (w_req_col[o]),
            .i_ptr (r_ptr[o]),
            .o_gnt (w_arb_gnt[o]),
            .o_idx (w_arb_idx[o])
        );
        assign w_arb_any[o]  = |w_arb_gnt[o];
        assign w_eligible[o] = (r_state[o] == ST_FREE) &&
                               (in_out_credits[o*P_CREDIT_WIDTH +: P_CREDIT_WIDTH] != '0);
        assign out_xbar_sel[o*P_SEL_WIDTH +: P_SEL_WIDTH] = w_sel[o];
    end

    // Per-output FREE/LOCKED next state, owner capture and pointer advance
    always_comb begin
        w_rel = '0;
        for (int o = 0; o < P_CHANNELS; o++) begin
            w_state_nxt[o] = r_state[o];
            w_owner_nxt[o] = r_owner[o];
            w_ptr_nxt[o]   = r_ptr[o];
            for (int i = 0; i < P_CHANNELS; i++) begin
                w_rel[o] = w_rel[o] | (in_release[i] && (r_owner[o] == P_SEL_WIDTH'(i)));
            end
            case (r_state[o])
                ST_FREE: begin
                    if (w_eligible[o] && w_arb_any[o]) begin
                        w_state_nxt[o] = ST_LOCKED;
                        w_owner_nxt[o] = w_arb_idx[o];
                        w_ptr_nxt[o]   = (w_arb_idx[o] == P_SEL_WIDTH'(P_CHANNELS-1)) ?
                                         '0 : w_arb_idx[o] + P_SEL_WIDTH'(1);
                    end else begin
                        w_state_nxt[o] = ST_FREE;
                    end
                end
                ST_LOCKED: begin
                    if (w_rel[o]) begin
                        w_state_nxt[o] = ST_FREE;
                    end else begin
                        w_state_nxt[o] = ST_LOCKED;
                    end
                end
                default: w_state_nxt[o] = ST_FREE;
            endcase
        end
    end

    // State, owner, pointer and error registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int o = 0; o < P_CHANNELS; o++) begin
                r_state[o] <= ST_FREE;
                r_owner[o] <= '0;
                r_ptr[o]   <= '0;
            end
            r_req_error <= 1'b0;
        end else begin
            for (int o = 0; o < P_CHANNELS; o++) begin
                r_state[o] <= w_state_nxt[o];
                r_owner[o] <= w_owner_nxt[o];
                r_ptr[o]   <= w_ptr_nxt[o];
            end
            r_req_error <= w_req_err;
        end
    end

    // Decode locked outputs into grant, crossbar select and valid
    always_comb begin
        w_grant = '0;
        for (int o = 0; o < P_CHANNELS; o++) begin
            w_valid[o] = (r_state[o] == ST_LOCKED);
            w_sel[o]   = w_valid[o] ? r_owner[o] : '0;
            for (int i = 0; i < P_CHANNELS; i++) begin
                w_grant[i] = w_grant[i] | (w_valid[o] && (r_owner[o] == P_SEL_WIDTH'(i)));
            end
        end
    end

    assign out_sa_grant   = w_grant;
    assign out_xbar_valid = w_valid;
    assign out_req_error  = r_req_error;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed self-checking bench for switch_allocator (5 channels, 4-bit credits).
`timescale 1ns/1ps
module tb_switch_allocator;

    logic        CLK = 1'b0;
    logic        RST;
    logic [4:0]  in_sa_enable;
    logic [24:0] in_sa_request;
    logic [4:0]  in_release;
    logic [19:0] in_out_credits;
    logic [4:0]  out_sa_grant;
    logic [14:0] out_xbar_sel;
    logic [4:0]  out_xbar_valid;
    logic        out_req_error;

    int n_checks = 0;
    int n_fail   = 0;

    switch_allocator dut (
        .CLK            (CLK),
        .RST            (RST),
        .in_sa_enable   (in_sa_enable),
        .in_sa_request  (in_sa_request),
        .in_release     (in_release),
        .in_out_credits (in_out_credits),
        .out_sa_grant   (out_sa_grant),
        .out_xbar_sel   (out_xbar_sel),
        .out_xbar_valid (out_xbar_valid),
        .out_req_error  (out_req_error)
    );

    always #5 CLK = ~CLK;

    function automatic logic [2:0] sel(input int o);
        return out_xbar_sel[o*3 +: 3];
    endfunction

    task automatic set_req(input int i, input logic [4:0] v);
        in_sa_request[i*5 +: 5] = v;
    endtask

    task automatic set_credit(input int o, input logic [3:0] c);
        in_out_credits[o*4 +: 4] = c;
    endtask

    task automatic pulse_release(input int i);
        in_release[i]   = 1'b1;
        in_sa_enable[i] = 1'b0;
        @(negedge CLK);
        in_release[i] = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b0;
        in_sa_enable = 5'b0; in_sa_request = 25'b0; in_release = 5'b0;
        in_out_credits = {5{4'd4}};
        repeat (2) @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b0) begin n_fail++; $display("FAIL reset_grant: got %b expected %b", out_sa_grant, 5'b0); end
        n_checks++; if (out_xbar_valid !== 5'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected %b", out_xbar_valid, 5'b0); end
        n_checks++; if (out_xbar_sel !== 15'b0) begin n_fail++; $display("FAIL reset_sel: got %h expected %h", out_xbar_sel, 15'b0); end
        n_checks++; if (out_req_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected %b", out_req_error, 1'b0); end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single;
        in_sa_enable[2] = 1'b1; set_req(2, 5'b00010);
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b00100) begin n_fail++; $display("FAIL single_grant: got %b expected %b", out_sa_grant, 5'b00100); end
        n_checks++; if (sel(1) !== 3'd2) begin n_fail++; $display("FAIL single_sel: got %0d expected %0d", sel(1), 2); end
        n_checks++; if (out_xbar_valid !== 5'b00010) begin n_fail++; $display("FAIL single_valid: got %b expected %b", out_xbar_valid, 5'b00010); end
        in_sa_enable[2] = 1'b0;
        repeat (2) @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b00100) begin n_fail++; $display("FAIL single_hold: got %b expected %b", out_sa_grant, 5'b00100); end
        pulse_release(2);
        n_checks++; if (out_sa_grant !== 5'b0) begin n_fail++; $display("FAIL single_release_grant: got %b expected %b", out_sa_grant, 5'b0); end
        n_checks++; if (out_xbar_valid !== 5'b0 || sel(1) !== 3'd0) begin n_fail++; $display("FAIL single_release_out: got valid %b sel %0d expected 00000 / 0", out_xbar_valid, sel(1)); end
    endtask

    task automatic test_contention;
        set_req(0, 5'b00100); set_req(3, 5'b00100); set_req(4, 5'b00100);
        in_sa_enable = 5'b11001;
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b00001 || sel(2) !== 3'd0) begin n_fail++; $display("FAIL cont_first: got %b sel %0d expected 00001 sel 0", out_sa_grant, sel(2)); end
        pulse_release(0);
        n_checks++; if (out_sa_grant !== 5'b0) begin n_fail++; $display("FAIL cont_idle1: got %b expected %b", out_sa_grant, 5'b0); end
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b01000 || sel(2) !== 3'd3) begin n_fail++; $display("FAIL cont_second: got %b sel %0d expected 01000 sel 3", out_sa_grant, sel(2)); end
        pulse_release(3);
        n_checks++; if (out_sa_grant !== 5'b0) begin n_fail++; $display("FAIL cont_idle2: got %b expected %b", out_sa_grant, 5'b0); end
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b10000 || sel(2) !== 3'd4) begin n_fail++; $display("FAIL cont_third: got %b sel %0d expected 10000 sel 4", out_sa_grant, sel(2)); end
        pulse_release(4);
        // Pointer must have wrapped to 0, so input 0 beats input 4
        in_sa_enable = 5'b10001;
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b00001) begin n_fail++; $display("FAIL cont_wrap: got %b expected %b", out_sa_grant, 5'b00001); end
        in_sa_enable[4] = 1'b0;
        pulse_release(0);
        @(negedge CLK);
        in_sa_request = 25'b0;
    endtask

    task automatic test_credit;
        set_credit(0, 4'd0);
        in_sa_enable[1] = 1'b1; set_req(1, 5'b00001);
        repeat (2) @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b0 || out_xbar_valid !== 5'b0) begin n_fail++; $display("FAIL credit_block: got grant %b valid %b expected 00000 / 00000", out_sa_grant, out_xbar_valid); end
        set_credit(0, 4'd1);
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b00010 || sel(0) !== 3'd1 || out_xbar_valid !== 5'b00001) begin n_fail++; $display("FAIL credit_grant: got %b sel %0d valid %b expected 00010 sel 1 valid 00001", out_sa_grant, sel(0), out_xbar_valid); end
        set_credit(0, 4'd0);
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b00010) begin n_fail++; $display("FAIL credit_hold: got %b expected %b", out_sa_grant, 5'b00010); end
        pulse_release(1);
        set_credit(0, 4'd4);
        in_sa_request = 25'b0;
    endtask

    task automatic test_malformed;
        in_sa_enable[3] = 1'b1; set_req(3, 5'b00110);
        @(negedge CLK);
        in_sa_enable[3] = 1'b0;
        n_checks++; if (out_req_error !== 1'b1 || out_sa_grant !== 5'b0) begin n_fail++; $display("FAIL mal_multi: got err %b grant %b expected 1 / 00000", out_req_error, out_sa_grant); end
        @(negedge CLK);
        n_checks++; if (out_req_error !== 1'b0) begin n_fail++; $display("FAIL mal_pulse: got %b expected %b", out_req_error, 1'b0); end
        in_sa_enable[3] = 1'b1; set_req(3, 5'b00000);
        @(negedge CLK);
        in_sa_enable[3] = 1'b0;
        n_checks++; if (out_req_error !== 1'b1 || out_sa_grant !== 5'b0) begin n_fail++; $display("FAIL mal_zero: got err %b grant %b expected 1 / 00000", out_req_error, out_sa_grant); end
        @(negedge CLK);
        n_checks++; if (out_req_error !== 1'b0) begin n_fail++; $display("FAIL mal_zero_pulse: got %b expected %b", out_req_error, 1'b0); end
        in_sa_request = 25'b0;
    endtask

    task automatic test_back_to_back;
        in_sa_enable[0] = 1'b1; set_req(0, 5'b01000);
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b00001 || sel(3) !== 3'd0) begin n_fail++; $display("FAIL b2b_own: got %b sel %0d expected 00001 sel 0", out_sa_grant, sel(3)); end
        in_sa_enable[0] = 1'b0;
        in_sa_enable[1] = 1'b1; set_req(1, 5'b01000);
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b00001) begin n_fail++; $display("FAIL b2b_locked: got %b expected %b", out_sa_grant, 5'b00001); end
        pulse_release(0);
        n_checks++; if (out_sa_grant !== 5'b0 || out_xbar_valid !== 5'b0) begin n_fail++; $display("FAIL b2b_no_bypass: got grant %b valid %b expected 00000 / 00000", out_sa_grant, out_xbar_valid); end
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b00010 || sel(3) !== 3'd1) begin n_fail++; $display("FAIL b2b_next: got %b sel %0d expected 00010 sel 1", out_sa_grant, sel(3)); end
        pulse_release(1);
        in_sa_request = 25'b0;
    endtask

    task automatic test_reset_mid;
        // Output 1 pointer sits at 3 here, so input 4 beats input 2 before reset
        set_req(2, 5'b00010); set_req(4, 5'b00010); set_req(0, 5'b10000);
        in_sa_enable = 5'b10101;
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b10001 || out_xbar_valid !== 5'b10010 || sel(1) !== 3'd4) begin n_fail++; $display("FAIL rst_pre: got %b valid %b sel1 %0d expected 10001 / 10010 / 4", out_sa_grant, out_xbar_valid, sel(1)); end
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        n_checks++; if (out_sa_grant !== 5'b0 || out_xbar_valid !== 5'b0 || out_xbar_sel !== 15'b0) begin n_fail++; $display("FAIL rst_async: got %b valid %b sel %h expected all zero", out_sa_grant, out_xbar_valid, out_xbar_sel); end
        #1 RST = 1'b1;
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b0) begin n_fail++; $display("FAIL rst_after: got %b expected %b", out_sa_grant, 5'b0); end
        @(negedge CLK);
        n_checks++; if (out_sa_grant !== 5'b00101 || sel(1) !== 3'd2 || sel(4) !== 3'd0) begin n_fail++; $display("FAIL rst_rearb: got %b sel1 %0d sel4 %0d expected 00101 / 2 / 0", out_sa_grant, sel(1), sel(4)); end
        in_sa_enable = 5'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_credit();
        test_malformed();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
